usrp_tag_tx_burst_framer: RTL and testbench
===========================================

# usrp_tag_tx_burst_framer

Downstream stage of the tag-chip MTX controller. Captures the controller's `itx`/`qtx` sample stream while `tx_trig` is high and buffers it in a small FIFO. Emits the samples as fixed-size, tlast-delimited packets on a valid/ready stream toward the radio TX path. Partial packets at burst abort are zero-padded, and overflow is reported rather than back-pressured, because the upstream controller cannot stall.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of each I/Q component.
- `NSYMB_WIDTH`, 16: width of the symbol index input.
- `SPP`, 256: samples per packet (≥2).
- `BURST_PKTS`, 64: packets per complete burst (≥1).
- `FIFO_AW`, 9: FIFO address width; depth is 2^FIFO_AW and must be ≥ `SPP`.

Ports:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `itx`  in  DATA_WIDTH  I sample from the MTX controller.
- `qtx`  in  DATA_WIDTH  Q sample from the MTX controller.
- `tx_valid`  in  1  input sample qualifier.
- `tx_trig`  in  1  burst gate; a rising edge starts a burst, a falling edge aborts it.
- `symbN`  in  NSYMB_WIDTH  symbol index; latched into `burst_symb` at burst start.
- `o_tdata`  out  2*DATA_WIDTH  {I, Q}.
- `o_tvalid`  out  1  output valid.
- `o_tlast`  out  1  last sample of a packet.
- `o_tready`  in  1  downstream ready.
- `burst_active`  out  1  high in RUN or PAD.
- `burst_symb`  out  NSYMB_WIDTH  `symbN` captured at burst start.
- `overflow`  out  1  sticky; cleared only by `reset`.
- `drop_count`  out  16  number of dropped samples; saturates at 0xFFFF.

## Operation
State machine:
- IDLE
  - Rising edge of `tx_trig` (registered previous value 0, current value 1) moves to RUN.
  - On that transition: clear `samp_cnt` and `pkt_cnt`, and latch `symbN` into `burst_symb`.
- RUN
  - A cycle with `tx_valid` and the FIFO not full writes {last, itx, qtx}.
  - The last bit is set when `samp_cnt == SPP-1`.
  - `samp_cnt` wraps to 0 at `SPP-1` and `pkt_cnt` increments.
  - When a write completes packet `BURST_PKTS-1`, go to IDLE.
  - If `tx_trig` is low: go to IDLE when `samp_cnt == 0`, otherwise go to PAD.
  - A falling edge in the same cycle as a valid sample: the sample is not written; the abort takes priority.
- PAD
  - Write {0, 0} samples, one per cycle while the FIFO is not full.
  - The final pad write carries last=1.
  - Return to IDLE when `samp_cnt` wraps.
  - `tx_valid` is ignored in PAD.
- A `tx_trig` rising edge outside IDLE is ignored. A new burst requires a fresh edge after returning to IDLE.

Overflow and output:
- Overflow: in RUN, `tx_valid` with the FIFO full drops the sample, does not advance `samp_cnt`, sets `overflow`, and increments `drop_count`.
- Output: the FIFO head is presented on `o_tdata`/`o_tlast` with `o_tvalid` = not empty. A pop occurs when `o_tvalid & o_tready`.
- Simultaneous push and pop on a full FIFO: the push is refused. The full flag is evaluated before the pop.

## Timing
- Reset values: `o_tvalid`, `o_tlast`, `o_tdata`, `burst_active`, `burst_symb`, `overflow` and `drop_count` are all 0. The FIFO is emptied and the state is IDLE.
- `reset` asserted mid-burst discards all buffered data on the next edge.
- `tx_trig` edge detection uses one register. A sample arriving in the same cycle as the rising edge is not written; the first accepted sample is on the cycle after the edge.
- Latency: a sample written at edge k is visible on `o_tvalid` after edge k+1 (1-cycle FIFO read latency). Data holds stable while `o_tvalid & !o_tready`.
- `burst_active` rises the cycle after the rising edge and falls the cycle after the final write.
- Throughput: one sample per cycle in and one sample per cycle out.

## Structure
- Shared package `usrp_tag_pkg`: the `tx_sample_t` packed struct {last, i, q} and the state enum {IDLE, RUN, PAD}.
- One sub-module, `usrp_tag_sync_fifo`: synchronous FIFO, parameterised on width and address width, with full/empty flags and a registered read.
- The FSM and the counters stay in the top level.

## Test plan
- SPP=4, BURST_PKTS=2, `tx_trig` high, `tx_valid` continuous with I=n, Q=-n, `o_tready`=1 → 8 output beats with I=0..7 (counting from the first sample after the edge), tlast on beats 3 and 7, then IDLE.
- Abort after 6 samples (SPP=4) → beats 0..5, then two zero beats; tlast on beats 3 and 7.
- `o_tready`=0 with FIFO_AW=3 and 10 samples → 8 buffered, `overflow`=1, `drop_count`=2, and the held output is unchanged.
- A second rising edge of `tx_trig` during PAD → ignored. A new edge in IDLE restarts with `burst_symb` equal to the current `symbN`.
- `reset` pulsed mid-burst with 3 samples buffered → the next cycle has `o_tvalid`=0, IDLE, and `drop_count`=0.
- Random `o_tready` with 50% duty → output sequence equals input sequence, and a tlast appears every SPP beats.

Source files
------------

// File: rtl/usrp_tag_pkg.sv
// Shared types for the tag-chip TX burst framer: framer states and the
// FIFO sample layout {last, i, q}.
package usrp_tag_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_PAD  = 2'd2;

    localparam int TAG_DW = 16;

    // Layout at the default component width; the framer rebuilds it at DATA_WIDTH.
    typedef struct packed {
        logic              last;
        logic [TAG_DW-1:0] i;
        logic [TAG_DW-1:0] q;
    } tx_sample_t;

endpackage

// File: rtl/usrp_tag_sync_fifo.sv
// Synchronous FIFO with a registered output stage; total capacity (memory plus
// output register) is 2^AW entries.
module usrp_tag_sync_fifo
    import usrp_tag_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      mem_cnt, used;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             push, pop, load;

    assign mem_cnt = wr_ptr_q - rd_ptr_q;
    assign used    = mem_cnt + {{AW{1'b0}}, out_valid_q};
    assign full_o  = (used == (AW+1)'(DEPTH));
    // Full is judged before any same-cycle pop, so a push into a full FIFO is refused.
    assign push    = push_i & ~full_o;
    assign pop     = pop_i & out_valid_q;
    assign load    = (mem_cnt != '0) & (~out_valid_q | pop);

    assign rdata_o = out_data_q;
    assign valid_o = out_valid_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (load) begin
                out_data_q  <= mem_q[rd_ptr_q[AW-1:0]];
                rd_ptr_q    <= rd_ptr_q + (AW+1)'(1);
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/usrp_tag_tx_burst_framer.sv
// Frames the MTX controller's I/Q stream into fixed-size tlast packets while
// tx_trig is high; aborted packets are zero-padded, overflow drops and counts.
module usrp_tag_tx_burst_framer
    import usrp_tag_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NSYMB_WIDTH = 16,
    parameter int SPP         = 256,
    parameter int BURST_PKTS  = 64,
    parameter int FIFO_AW     = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   itx,
    input  logic [DATA_WIDTH-1:0]   qtx,
    input  logic                    tx_valid,
    input  logic                    tx_trig,
    input  logic [NSYMB_WIDTH-1:0]  symbN,
    output logic [2*DATA_WIDTH-1:0] o_tdata,
    output logic                    o_tvalid,
    output logic                    o_tlast,
    input  logic                    o_tready,
    output logic                    burst_active,
    output logic [NSYMB_WIDTH-1:0]  burst_symb,
    output logic                    overflow,
    output logic [15:0]             drop_count
);
    localparam int SW = $clog2(SPP);
    localparam int PW = (BURST_PKTS > 1) ? $clog2(BURST_PKTS) : 1;
    localparam int FW = 2*DATA_WIDTH + 1;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] i;
        logic [DATA_WIDTH-1:0] q;
    } sample_t;

    state_t                 state_q, state_d;
    logic                   trig_q;
    logic [SW-1:0]          samp_cnt_q, samp_cnt_d;
    logic [PW-1:0]          pkt_cnt_q, pkt_cnt_d;
    logic [NSYMB_WIDTH-1:0] symb_q, symb_d;
    logic                   ovf_q, ovf_d;
    logic [15:0]            drop_q, drop_d;

    logic    trig_rise, samp_last, pkt_last;
    logic    push, fifo_full, fifo_valid;
    sample_t wr_sample, rd_sample;
    logic [FW-1:0] rd_word;

    assign trig_rise = tx_trig & ~trig_q;
    assign samp_last = (samp_cnt_q == SW'(SPP-1));
    assign pkt_last  = (pkt_cnt_q == PW'(BURST_PKTS-1));

    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        symb_d      = symb_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        push        = 1'b0;
        wr_sample   = '0;
        case (state_q)
            ST_IDLE: begin
                if (trig_rise) begin
                    state_d    = ST_RUN;
                    samp_cnt_d = '0;
                    pkt_cnt_d  = '0;
                    symb_d     = symbN;
                end
            end
            ST_RUN: begin
                // Abort wins over a sample arriving in the same cycle.
                if (!tx_trig) begin
                    state_d = (samp_cnt_q == '0) ? ST_IDLE : ST_PAD;
                end else if (tx_valid) begin
                    if (fifo_full) begin
                        ovf_d = 1'b1;
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                    end else begin
                        push           = 1'b1;
                        wr_sample.last = samp_last;
                        wr_sample.i    = itx;
                        wr_sample.q    = qtx;
                        if (samp_last) begin
                            samp_cnt_d = '0;
                            pkt_cnt_d  = pkt_cnt_q + PW'(1);
                            if (pkt_last) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            samp_cnt_d = samp_cnt_q + SW'(1);
                        end
                    end
                end
            end
            ST_PAD: begin
                if (!fifo_full) begin
                    push           = 1'b1;
                    wr_sample.last = samp_last;
                    if (samp_last) begin
                        samp_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        samp_cnt_d = samp_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            trig_q     <= 1'b0;
            samp_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            symb_q     <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= tx_trig;
            samp_cnt_q <= samp_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            symb_q     <= symb_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    usrp_tag_sync_fifo #(
        .WIDTH (FW),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (wr_sample),
        .pop_i   (fifo_valid & o_tready),
        .rdata_o (rd_word),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

    assign rd_sample    = sample_t'(rd_word);
    assign o_tdata      = {rd_sample.i, rd_sample.q};
    assign o_tlast      = rd_sample.last;
    assign o_tvalid     = fifo_valid;
    assign burst_active = (state_q != ST_IDLE);
    assign burst_symb   = symb_q;
    assign overflow     = ovf_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_usrp_tag_tx_burst_framer.sv
// Bench for the TX burst framer: directed bursts plus random traffic, checked
// against a queue-based packet model.
module tb_usrp_tag_tx_burst_framer;
    localparam int DW    = 16;
    localparam int NW    = 16;
    localparam int SPP   = 4;
    localparam int BP    = 3;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] itx, qtx;
    logic          tx_valid, tx_trig, o_tready;
    logic [NW-1:0] symbN;
    logic [2*DW-1:0] o_tdata;
    logic          o_tvalid, o_tlast, burst_active, overflow;
    logic [NW-1:0] burst_symb;
    logic [15:0]   drop_count;

    usrp_tag_tx_burst_framer #(
        .DATA_WIDTH(DW), .NSYMB_WIDTH(NW), .SPP(SPP), .BURST_PKTS(BP), .FIFO_AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .itx(itx), .qtx(qtx), .tx_valid(tx_valid),
        .tx_trig(tx_trig), .symbN(symbN), .o_tdata(o_tdata), .o_tvalid(o_tvalid),
        .o_tlast(o_tlast), .o_tready(o_tready), .burst_active(burst_active),
        .burst_symb(burst_symb), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        last;
        logic [31:0] data;
        int          wedge;
    } exp_t;

    exp_t        q[$];
    int          mode, sidx, pidx, edge_n, beat_n;
    logic        trig_prev, m_ovf;
    logic [15:0] m_symb, m_drops;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // mode: 0 idle, 1 collecting samples, 2 padding the open packet
    task automatic push_exp(input logic last, input logic [31:0] data);
        exp_t e;
        e.last  = last;
        e.data  = data;
        e.wedge = edge_n;
        q.push_back(e);
    endtask

    task automatic model_edge();
        bit full, vis, rise, lastp;
        if (reset) begin
            q.delete();
            mode = 0; sidx = 0; pidx = 0; trig_prev = 0;
            m_symb = '0; m_ovf = 0; m_drops = '0; beat_n = 0;
            edge_n++;
            return;
        end
        full = (q.size() == DEPTH);
        vis  = (q.size() > 0) && (q[0].wedge < edge_n);
        rise = tx_trig && !trig_prev;
        edge_n++;
        if (vis && o_tready) void'(q.pop_front());
        lastp = (sidx == SPP-1);
        if (mode == 0) begin
            if (rise) begin
                mode = 1; sidx = 0; pidx = 0; m_symb = symbN;
            end
        end else if (mode == 1) begin
            if (!tx_trig) begin
                mode = (sidx == 0) ? 0 : 2;
            end else if (tx_valid) begin
                if (full) begin
                    m_ovf = 1;
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end else begin
                    push_exp(lastp, {itx, qtx});
                    if (lastp) begin
                        sidx = 0;
                        if (pidx == BP-1) mode = 0;
                        else pidx++;
                    end else sidx++;
                end
            end
        end else begin
            if (!full) begin
                push_exp(lastp, 32'd0);
                if (lastp) begin
                    sidx = 0; mode = 0;
                end else sidx++;
            end
        end
        trig_prev = tx_trig;
    endtask

    task automatic compare_outputs();
        bit ev;
        ev = (q.size() > 0) && (q[0].wedge < edge_n);
        chk("tvalid", {31'd0, o_tvalid}, {31'd0, ev});
        if (ev) begin
            chk("tdata", o_tdata, q[0].data);
            chk("tlast", {31'd0, o_tlast}, {31'd0, q[0].last});
        end
        chk("burst_active", {31'd0, burst_active}, {31'd0, mode != 0});
        chk("burst_symb", {16'd0, burst_symb}, {16'd0, m_symb});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_count", {16'd0, drop_count}, {16'd0, m_drops});
    endtask

    task automatic step_cycle();
        if (!reset && o_tvalid === 1'b1 && o_tready) begin
            chk("tlast_period", {31'd0, o_tlast}, {31'd0, (beat_n % SPP) == SPP-1});
            beat_n++;
        end
        model_edge();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic drive(input bit trig, input bit valid, input bit rdy, input logic [15:0] i);
        tx_trig  = trig;
        tx_valid = valid;
        o_tready = rdy;
        itx      = i;
        qtx      = 16'd0 - i;
        step_cycle();
    endtask

    int start;

    initial begin
        edge_n = 0; beat_n = 0; mode = 0; sidx = 0; pidx = 0;
        trig_prev = 0; m_ovf = 0; m_drops = '0; m_symb = '0;
        reset = 1; tx_trig = 0; tx_valid = 0; o_tready = 0;
        itx = '0; qtx = '0; symbN = 16'h1234;

        repeat (3) step_cycle();
        chk("rst_tdata", o_tdata, 32'd0);
        chk("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("rst_drop", {16'd0, drop_count}, 32'd0);
        reset = 0;
        drive(0, 0, 1, 0);

        // complete burst, continuous input
        start = beat_n;
        drive(1, 1, 1, 16'hDEAD);
        for (int k = 0; k < 20; k++) drive(1, 1, 1, 16'(k));
        for (int k = 0; k < 5; k++) drive(0, 0, 1, 0);
        chk("burst_beats", beat_n - start, SPP*BP);
        chk("burst_symb_d", {16'd0, burst_symb}, 32'h1234);

        // abort after 6 samples, abort cycle carries a valid sample
        start = beat_n;
        drive(1, 1, 1, 16'd100);
        for (int k = 0; k < 6; k++) drive(1, 1, 1, 16'(k));
        drive(0, 1, 1, 16'd77);
        for (int k = 0; k < 10; k++) drive(0, 0, 1, 0);
        chk("abort_beats", beat_n - start, 8);

        // overflow with stalled output
        start = beat_n;
        drive(1, 1, 0, 16'd99);
        for (int k = 0; k < 10; k++) drive(1, 1, 0, 16'(k + 5));
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_drops", {16'd0, drop_count}, 32'd2);
        chk("ovf_held", o_tdata, {16'd5, 16'hFFFB});
        drive(0, 0, 0, 0);
        for (int k = 0; k < 12; k++) drive(0, 0, 1, 0);
        chk("ovf_beats", beat_n - start, 8);

        // rising edge during PAD is ignored; new edge in IDLE relatches symbN
        symbN = 16'hAAAA;
        drive(1, 1, 1, 16'd1);
        drive(1, 1, 1, 16'd2);
        drive(0, 0, 1, 0);
        for (int k = 0; k < 5; k++) drive(1, 0, 1, 0);
        chk("pad_edge_ignored", {31'd0, burst_active}, 32'd0);
        symbN = 16'h5555;
        drive(0, 0, 1, 0);
        drive(1, 0, 1, 0);
        chk("restart_active", {31'd0, burst_active}, 32'd1);
        chk("restart_symb", {16'd0, burst_symb}, 32'h5555);
        drive(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 0);

        // reset mid-burst with 3 buffered samples
        drive(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, 1, 0, 16'(k + 40));
        reset = 1;
        drive(1, 1, 0, 0);
        chk("midrst_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("midrst_active", {31'd0, burst_active}, 32'd0);
        chk("midrst_drop", {16'd0, drop_count}, 32'd0);
        reset = 0;
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);

        // random traffic with 50% ready
        tx_trig = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 24) == 0) tx_trig = ~tx_trig;
            symbN = 16'($urandom);
            drive(tx_trig, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 16'($urandom));
        end
        for (int k = 0; k < 40; k++) drive(0, 0, 1, 0);
        chk("final_empty", {31'd0, o_tvalid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
